seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
- Downstream of the octal 7-segment decoder.
- Takes the three active-low digit patterns (hundreds C, tens D, units U) of the 8-bit RPN result.
- Time-multiplexes them onto one shared segment bus with per-digit anode enables.
- Adds frame-synchronous update, inter-digit ghost blanking, leading-zero blanking and whole-display blink for error or overflow indication.

Parameters:
- DIV, 50000: clock cycles per digit slot; legal range ≥ GAP+1.
- GAP, 4: cycles at the end of each slot with all anodes off (anti-ghosting); legal range ≥ 0.
- BLINK_FRAMES, 64: full frames per blink half-period; legal range ≥ 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- load  in  1  one-cycle strobe; capture dig_c/dig_d/dig_u into the pending registers.
- dig_c  in  7  hundreds pattern, active-low, bit0=a … bit6=g.
- dig_d  in  7  tens pattern, same encoding.
- dig_u  in  7  units pattern, same encoding.
- blank_lz  in  1  enable leading-zero blanking.
- blink_en  in  1  enable whole-display blink.
- seg  out  7  shared segment bus, active-low.
- an  out  3  anode enables, active-low; an[2]=C, an[1]=D, an[0]=U.
- frame_done  out  1  one-cycle pulse at the end of each U slot.

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of clk. The following values hold while rst_n=0 and on the first cycle after release:
  - slot=S_C, div_cnt=0, blink_cnt=0, blink_phase=0.
  - pending and active registers = 7'h7F.
  - seg=7'h7F, an=3'b111, frame_done=0.
  - load is ignored during reset.
- Reset mid-frame aborts the scan immediately; there is no drain.
- Slot FSM: S_C -> S_D -> S_U -> S_C.
  - Advance when div_cnt==DIV-1; div_cnt then returns to 0.
  - Otherwise div_cnt increments.
- Frame boundary = the cycle with slot=S_U and div_cnt==DIV-1.
  - On that cycle, active <= pending (all three digits together).
- Load:
  - A load in any cycle writes pending on that edge.
  - A load on the frame-boundary cycle is copied to active one frame later. The boundary copies the old pending.
  - Back-to-back loads: the last one before a boundary wins.
- Drive window:
  - div_cnt < DIV-GAP: the current slot's anode is low.
  - div_cnt ≥ DIV-GAP: an=3'b111 and seg=7'h7F.
- Leading-zero blanking (blank_lz=1), with ZERO = 7'b1000000:
  - C is blanked when active_c==ZERO.
  - D is blanked when C is blanked and active_d==ZERO.
  - U is never blanked.
  - A blanked digit drives an=3'b111 and seg=7'h7F for its whole slot.
- Blink:
  - blink_cnt counts frame boundaries while blink_en=1.
  - When blink_cnt==BLINK_FRAMES-1 at a boundary: blink_phase toggles and blink_cnt clears.
  - While blink_en=1 and blink_phase=1: an=3'b111 and seg=7'h7F.
  - blink_en=0 clears blink_cnt and blink_phase on the next edge.
- Output latency: seg, an and frame_done are registered. They reflect the state (slot, div_cnt, active, flags) of the previous cycle, i.e. one cycle of latency.
- frame_done: high for exactly one cycle, the cycle after the frame boundary.
- Input handling: blank_lz and blink_en are sampled every cycle; there is no synchronisation requirement.

Test Plan (DIV=8, GAP=2, BLINK_FRAMES=2 unless noted; cycle 0 = first edge with rst_n=1):
1. Reset:
   - Hold rst_n=0 for 5 cycles with load=1 and dig_*=7'h00 -> seg=7'h7F and an=3'b111 throughout; no frame_done.
   - After release, cycles 1-24 show blank digits, since active = 7'h7F.
2. Scan timing:
   - Load C=7'h79, D=7'h24, U=7'h30 at cycle 0; they become active at cycle 23.
   - Frame 2 (cycles 25-48): an=3'b011 with seg=7'h79 for cycles 25-30, then an=3'b111 for cycles 31-32.
   - Then an=3'b101 with seg=7'h24 for cycles 33-38, then an=3'b110 with seg=7'h30 for cycles 41-46.
   - frame_done pulses at cycles 24 and 48 only.
3. Frame-synchronous load:
   - Loading new values at cycle 30 (mid-frame) -> no change until cycle 49; load at cycle 47 (the boundary) -> the new values appear from cycle 73, not 49.
4. Leading-zero blanking:
   - blank_lz=1, digits C=ZERO, D=ZERO, U=7'h79 -> only an=3'b110 ever goes active.
   - C=ZERO, D=7'h24 -> D and U are shown.
   - C=7'h79, D=ZERO -> all three are shown, with D displaying the zero pattern.
5. Blink:
   - blink_en=1 from cycle 0 -> normal display for frames 1-2, all off for frames 3-4, on for frames 5-6.
   - Dropping blink_en during an off phase -> display resumes next cycle+1.
6. Reset mid-operation:
   - Assert rst_n=0 for 1 cycle during slot D of a loaded display -> the next output is an=3'b111 and seg=7'h7F.
   - Scan restarts at S_C with blank digits until a new load passes a frame boundary.

Source files
------------

// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
//
// Time-multiplexes three active-low 7-segment patterns (hundreds C, tens D,
// units U) onto one shared segment bus with per-digit anode enables.
//
// New digits are captured into pending registers on load. They reach the
// display only at a frame boundary, so a frame never shows a mix of old and
// new digits. The last GAP cycles of every slot drive all anodes off to stop
// ghosting between digits. Leading-zero blanking and a whole-display blink
// are also provided.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   load       one-cycle strobe, captures dig_c/dig_d/dig_u into pending
//   dig_c      hundreds pattern, active-low, bit0=a .. bit6=g
//   dig_d      tens pattern, same encoding
//   dig_u      units pattern, same encoding
//   blank_lz   enable leading-zero blanking
//   blink_en   enable whole-display blink
//   seg        shared segment bus, active-low (registered)
//   an         anode enables, active-low, an[2]=C an[1]=D an[0]=U (registered)
//   frame_done one-cycle pulse the cycle after each frame boundary
// -----------------------------------------------------------------------------
module seg_scan_mux #(
    parameter int DIV          = 50000,
    parameter int GAP          = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [6:0] dig_c,
    input  logic [6:0] dig_d,
    input  logic [6:0] dig_u,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_done
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    // One bit wider than div_cnt so that GAP=0 (window end == DIV) still fits.
    localparam logic [DIV_W:0]   DRIVE_END = (DIV_W + 1)'(DIV - GAP);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

    localparam logic [6:0] ZERO    = 7'b1000000;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [2:0] AN_OFF  = 3'b111;

    typedef enum logic [1:0] {
        S_C,
        S_D,
        S_U
    } slot_t;

    slot_t            slot;
    logic [DIV_W-1:0] div_cnt;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_phase;

    logic [6:0] pend_c, pend_d, pend_u;
    logic [6:0] act_c, act_d, act_u;

    logic       boundary;
    logic       in_window;
    logic       blank_c;
    logic       blank_d;
    logic       blink_off;
    logic [6:0] nxt_seg;
    logic [2:0] nxt_an;

    // Decode of the current cycle's state into what the display should show.
    always_comb begin
        boundary  = (slot == S_U) && (div_cnt == DIV_LAST);
        in_window = ({1'b0, div_cnt} < DRIVE_END);
        // D can only be a leading zero if C already is one.
        blank_c   = blank_lz && (act_c == ZERO);
        blank_d   = blank_c && (act_d == ZERO);
        blink_off = blink_en && blink_phase;

        nxt_seg = SEG_OFF;
        nxt_an  = AN_OFF;
        case (slot)
            S_C: begin
                if (!blank_c) begin
                    nxt_seg = act_c;
                    nxt_an  = 3'b011;
                end
            end
            S_D: begin
                if (!blank_d) begin
                    nxt_seg = act_d;
                    nxt_an  = 3'b101;
                end
            end
            S_U: begin
                nxt_seg = act_u;
                nxt_an  = 3'b110;
            end
            default: begin
                nxt_seg = SEG_OFF;
                nxt_an  = AN_OFF;
            end
        endcase

        if (!in_window || blink_off) begin
            nxt_seg = SEG_OFF;
            nxt_an  = AN_OFF;
        end
    end

    // Scan state, digit registers, blink timer and the registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot        <= S_C;
            div_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            pend_c      <= SEG_OFF;
            pend_d      <= SEG_OFF;
            pend_u      <= SEG_OFF;
            act_c       <= SEG_OFF;
            act_d       <= SEG_OFF;
            act_u       <= SEG_OFF;
            seg         <= SEG_OFF;
            an          <= AN_OFF;
            frame_done  <= 1'b0;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                case (slot)
                    S_C:     slot <= S_D;
                    S_D:     slot <= S_U;
                    default: slot <= S_C;
                endcase
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            // The boundary copies the pending value from before this edge,
            // so a load landing on the boundary waits a full frame.
            if (boundary) begin
                act_c <= pend_c;
                act_d <= pend_d;
                act_u <= pend_u;
            end

            if (load) begin
                pend_c <= dig_c;
                pend_d <= dig_d;
                pend_u <= dig_u;
            end

            if (!blink_en) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (boundary) begin
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BLK_W'(1);
                end
            end

            // Output register stage: one cycle behind the scan state.
            seg        <= nxt_seg;
            an         <= nxt_an;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_mux
//
// Bench for seg_scan_mux with DIV=8, GAP=2, BLINK_FRAMES=2. A behavioural
// model tracks time since reset as a plain cycle number and derives slot,
// position in slot and frame boundaries from it arithmetically. Blink phase
// comes from the number of boundaries seen while blink is enabled. A negedge
// process compares every output against the model. Directed runs add
// literal expectations at fixed cycle numbers, and a randomized run follows.
// -----------------------------------------------------------------------------
module tb_seg_scan_mux;

    localparam int DIV   = 8;
    localparam int GAP   = 2;
    localparam int BF    = 2;
    localparam int FRAME = 3 * DIV;
    localparam logic [6:0] ZERO = 7'b1000000;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       load     = 1'b0;
    logic       blank_lz = 1'b0;
    logic       blink_en = 1'b0;
    logic [6:0] dig_c    = 7'h00;
    logic [6:0] dig_d    = 7'h00;
    logic [6:0] dig_u    = 7'h00;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_done;

    seg_scan_mux #(
        .DIV          (DIV),
        .GAP          (GAP),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .dig_c      (dig_c),
        .dig_d      (dig_d),
        .dig_u      (dig_u),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: t = index of the cycle being evaluated since reset release.
    int         t    = 0;
    int         m_nb = 0;
    logic [6:0] m_pend [3];
    logic [6:0] m_act  [3];

    logic [6:0] nx_seg, exp_seg;
    logic [2:0] nx_an, exp_an;
    logic       nx_fd, exp_fd;
    bit         chk_en = 1'b0;

    logic [6:0] obs_seg [256];
    logic [2:0] obs_an  [256];
    logic       obs_fd  [256];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
        end
    endtask

    // Output for the cycle after t, then advance the model by one cycle.
    task automatic model_eval();
        int   slot;
        int   pos;
        bit   bnd;
        bit   shown;
        bit   lz_c;
        bit   lz_d;
        if (!rst_n) begin
            nx_seg = 7'h7F;
            nx_an  = 3'b111;
            nx_fd  = 1'b0;
            t      = 0;
            m_nb   = 0;
            for (int k = 0; k < 3; k++) begin
                m_pend[k] = 7'h7F;
                m_act[k]  = 7'h7F;
            end
            return;
        end
        slot  = (t / DIV) % 3;
        pos   = t % DIV;
        bnd   = ((t % FRAME) == FRAME - 1);
        lz_c  = blank_lz && (m_act[0] == ZERO);
        lz_d  = lz_c && (m_act[1] == ZERO);
        shown = (pos < DIV - GAP) && !(blink_en && (((m_nb / BF) % 2) == 1));
        if (slot == 0 && lz_c) shown = 1'b0;
        if (slot == 1 && lz_d) shown = 1'b0;
        nx_an  = shown ? ~(3'b100 >> slot) : 3'b111;
        nx_seg = shown ? m_act[slot] : 7'h7F;
        nx_fd  = bnd;
        if (bnd) begin
            for (int k = 0; k < 3; k++) m_act[k] = m_pend[k];
        end
        if (load) begin
            m_pend[0] = dig_c;
            m_pend[1] = dig_d;
            m_pend[2] = dig_u;
        end
        if (!blink_en) m_nb = 0;
        else if (bnd) m_nb++;
        t++;
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        exp_seg = nx_seg;
        exp_an  = nx_an;
        exp_fd  = nx_fd;
        chk_en  = 1'b1;
        if (t < 256) begin
            obs_seg[t] = seg;
            obs_an[t]  = an;
            obs_fd[t]  = frame_done;
        end
    endtask

    task automatic set_dig(input logic [6:0] c, input logic [6:0] d, input logic [6:0] u);
        dig_c = c;
        dig_d = d;
        dig_u = u;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        load  = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("seg", 32'(seg), 32'(exp_seg));
            chk("an", 32'(an), 32'(exp_an));
            chk("frame_done", 32'(frame_done), 32'(exp_fd));
        end
    end

    int hidden;

    initial begin
        // Reset held with load active and all-segments-on digits.
        rst_n = 1'b0;
        load  = 1'b1;
        set_dig(7'h00, 7'h00, 7'h00);
        repeat (5) step();
        chk("rst_an", 32'(an), 32'h7);
        chk("rst_seg", 32'(seg), 32'h7F);
        rst_n = 1'b1;

        // Scan timing and frame-synchronous load.
        while (t < 82) begin
            load = 1'b0;
            if (t == 0) begin
                load = 1'b1; set_dig(7'h79, 7'h24, 7'h30);
            end else if (t == 30) begin
                load = 1'b1; set_dig(7'h12, 7'h02, 7'h78);
            end else if (t == 47) begin
                load = 1'b1; set_dig(7'h19, 7'h00, 7'h08);
            end
            step();
        end
        load = 1'b0;
        chk("blank_f1_an", 32'(obs_an[20]), 32'h6);
        chk("blank_f1_seg", 32'(obs_seg[20]), 32'h7F);
        chk("fd_23", 32'(obs_fd[23]), 32'h0);
        chk("fd_24", 32'(obs_fd[24]), 32'h1);
        chk("fd_25", 32'(obs_fd[25]), 32'h0);
        chk("fd_48", 32'(obs_fd[48]), 32'h1);
        chk("fd_72", 32'(obs_fd[72]), 32'h1);
        chk("c_an_25", 32'(obs_an[25]), 32'h3);
        chk("c_seg_25", 32'(obs_seg[25]), 32'h79);
        chk("c_an_30", 32'(obs_an[30]), 32'h3);
        chk("gap_an_31", 32'(obs_an[31]), 32'h7);
        chk("gap_seg_32", 32'(obs_seg[32]), 32'h7F);
        chk("d_an_33", 32'(obs_an[33]), 32'h5);
        chk("d_seg_33", 32'(obs_seg[33]), 32'h24);
        chk("u_an_41", 32'(obs_an[41]), 32'h6);
        chk("u_seg_41", 32'(obs_seg[41]), 32'h30);
        chk("u_an_46", 32'(obs_an[46]), 32'h6);
        chk("midload_c_49", 32'(obs_seg[49]), 32'h12);
        chk("midload_d_57", 32'(obs_seg[57]), 32'h02);
        chk("midload_u_65", 32'(obs_seg[65]), 32'h78);
        chk("bndload_c_73", 32'(obs_seg[73]), 32'h19);
        chk("pre_rst_an", 32'(obs_an[82]), 32'h5);
        chk("pre_rst_seg", 32'(obs_seg[82]), 32'h00);

        // One-cycle reset in slot D.
        rst_n = 1'b0;
        step();
        chk("mid_rst_an", 32'(an), 32'h7);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        rst_n = 1'b1;
        repeat (30) step();
        chk("post_rst_an_1", 32'(obs_an[1]), 32'h3);
        chk("post_rst_seg_1", 32'(obs_seg[1]), 32'h7F);
        chk("post_rst_seg_25", 32'(obs_seg[25]), 32'h7F);

        // Leading-zero blanking.
        do_reset(2);
        blank_lz = 1'b1;
        while (t < 100) begin
            load = 1'b0;
            if (t == 0) begin
                load = 1'b1; set_dig(ZERO, ZERO, 7'h79);
            end else if (t == 30) begin
                load = 1'b1; set_dig(ZERO, 7'h24, 7'h30);
            end else if (t == 50) begin
                load = 1'b1; set_dig(7'h79, ZERO, 7'h30);
            end
            step();
        end
        load = 1'b0;
        hidden = 0;
        for (int k = 25; k <= 48; k++) begin
            if (obs_an[k] == 3'b011 || obs_an[k] == 3'b101) hidden++;
        end
        chk("lz_cd_hidden", 32'(hidden), 32'h0);
        chk("lz_u_an_41", 32'(obs_an[41]), 32'h6);
        chk("lz_u_seg_41", 32'(obs_seg[41]), 32'h79);
        chk("lz_c_an_49", 32'(obs_an[49]), 32'h7);
        chk("lz_d_an_57", 32'(obs_an[57]), 32'h5);
        chk("lz_d_seg_57", 32'(obs_seg[57]), 32'h24);
        chk("lz_c_an_73", 32'(obs_an[73]), 32'h3);
        chk("lz_d_an_81", 32'(obs_an[81]), 32'h5);
        chk("lz_d_seg_81", 32'(obs_seg[81]), 32'h40);
        blank_lz = 1'b0;

        // Blink.
        do_reset(2);
        blink_en = 1'b1;
        while (t < 170) begin
            load = 1'b0;
            if (t == 0) begin
                load = 1'b1; set_dig(7'h79, 7'h24, 7'h30);
            end
            if (t == 152) blink_en = 1'b0;
            step();
        end
        load = 1'b0;
        chk("blink_on_25", 32'(obs_an[25]), 32'h3);
        chk("blink_off_49", 32'(obs_an[49]), 32'h7);
        chk("blink_off_73", 32'(obs_an[73]), 32'h7);
        chk("blink_on_97", 32'(obs_an[97]), 32'h3);
        chk("blink_off_145", 32'(obs_an[145]), 32'h7);
        chk("blink_drop_an_153", 32'(obs_an[153]), 32'h5);
        chk("blink_drop_seg_153", 32'(obs_seg[153]), 32'h24);

        // Randomized run against the model.
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            load  = ($urandom_range(0, 19) == 0);
            dig_c = ($urandom_range(0, 2) == 0) ? ZERO : 7'($urandom);
            dig_d = ($urandom_range(0, 2) == 0) ? ZERO : 7'($urandom);
            dig_u = ($urandom_range(0, 2) == 0) ? ZERO : 7'($urandom);
            if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 149) == 0) blink_en = ~blink_en;
            step();
        end
        rst_n = 1'b1;
        load  = 1'b0;

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
